smoldvi_tmds_encode: RTL and testbench

//  DVI 1.0 TMDS encoder for one lane: pixel-rate 8b video or 2b control in, 10b DC-balanced symbol out.
//  One instance per lane (R/G/B), clocked by the pixel clock. Symbols go to the 10:1 lane serialiser.
//  The lane serialiser runs beside the pseudo-differential pixel-clock driver on clk_x5.

---
 rtl/smoldvi_pkg.sv | 39 +++
 rtl/smoldvi_tmds_qm.sv | 30 +++
 rtl/smoldvi_tmds_encode.sv | 137 +++++++++++++
 tb/tb_smoldvi_tmds_encode.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/smoldvi_pkg.sv
// smoldvi_pkg: shared constants and helpers for the smoldvi TMDS encoder.
// Holds the fixed control and TERC4 symbol tables, the symbol width and the
// default disparity counter width, plus a small popcount helper.
package smoldvi_pkg;

  localparam int TMDS_W         = 10;
  localparam int DISP_W_DEFAULT = 5;

  // Control symbols indexed by {c1,c0}; entry 0 is also the reset/idle symbol.
  localparam logic [3:0][TMDS_W-1:0] CTRL_SYM = {
    10'h2AB, 10'h154, 10'h0AB, 10'h354
  };

  // HDMI TERC4 data-island symbols indexed by the 4-bit aux nibble.
  localparam logic [15:0][TMDS_W-1:0] TERC4_SYM = {
    10'h2C3, 10'h163, 10'h271, 10'h28E,
    10'h2C6, 10'h19C, 10'h139, 10'h2CC,
    10'h13C, 10'h18E, 10'h11E, 10'h171,
    10'h2E2, 10'h2E4, 10'h263, 10'h29C
  };

  // Which of the three DC-balancing rules the video path applied this cycle.
  typedef enum logic [1:0] {
    ENC_BALANCED = 2'd0,
    ENC_INVERT   = 2'd1,
    ENC_PASS     = 2'd2
  } enc_case_e;

  // Number of set bits in a byte (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/smoldvi_tmds_qm.sv
// smoldvi_tmds_qm: combinational TMDS transition-minimisation stage.
// Turns a video byte into the 9-bit q_m word (bit 8 flags XOR vs XNOR
// chaining) and reports how many ones sit in q_m[7:0].
module smoldvi_tmds_qm
  import smoldvi_pkg::*;
(
  input  logic [7:0] d_i,
  output logic [8:0] qm_o,
  output logic [3:0] n1q_o
);

  logic [3:0] n1d;
  logic       useXnor;
  logic [8:0] qm;

  // Pick XNOR chaining for ones-heavy bytes so the word has fewer transitions.
  always_comb begin
    n1d     = popcount8(d_i);
    useXnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d_i[0]);
    qm      = '0;
    qm[0]   = d_i[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = useXnor ? ~(qm[i-1] ^ d_i[i]) : (qm[i-1] ^ d_i[i]);
    end
    qm[8]   = ~useXnor;
    qm_o    = qm;
    n1q_o   = popcount8(qm[7:0]);
  end

endmodule

// File: rtl/smoldvi_tmds_encode.sv
// smoldvi_tmds_encode: one-lane DVI TMDS encoder, two-stage pipeline.
// Stage 1 registers the transition-minimised word; stage 2 applies running
// disparity balancing or emits a control symbol.
// Optional macro SMOLDVI_TMDS_TERC4_EN adds island/aux ports for HDMI
// data-island TERC4 symbols; the default build is a plain DVI encoder.
module smoldvi_tmds_encode
  import smoldvi_pkg::*;
#(
  parameter int DISP_W     = DISP_W_DEFAULT,
  parameter bit INVERT_OUT = 1'b0
) (
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic              de,
  input  logic [7:0]        d,
  input  logic [1:0]        c,
`ifdef SMOLDVI_TMDS_TERC4_EN
  input  logic              island,
  input  logic [3:0]        aux,
`endif
  output logic [TMDS_W-1:0] q_out
);

  logic [8:0]        qm_d;
  logic [3:0]        n1q_d;

  logic [8:0]        qm_s1_q;
  logic [3:0]        n1q_s1_q;
  logic              de_s1_q;
  logic [1:0]        c_s1_q;
`ifdef SMOLDVI_TMDS_TERC4_EN
  logic              island_s1_q;
  logic [3:0]        aux_s1_q;
`endif

  logic [DISP_W-1:0] cnt_q;
  logic [DISP_W-1:0] cnt_d;
  logic [TMDS_W-1:0] sym_q;
  logic [TMDS_W-1:0] sym_d;

  logic [DISP_W-1:0] diff;
  logic [DISP_W-1:0] two;
  logic              cntZero;
  logic              cntNeg;
  logic              cntPos;
  enc_case_e         encCase;

  smoldvi_tmds_qm u_qm (
    .d_i   (d),
    .qm_o  (qm_d),
    .n1q_o (n1q_d)
  );

  // Stage 1: capture the minimised word and the side-band controls.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      qm_s1_q     <= '0;
      n1q_s1_q    <= '0;
      de_s1_q     <= 1'b0;
      c_s1_q      <= '0;
`ifdef SMOLDVI_TMDS_TERC4_EN
      island_s1_q <= 1'b0;
      aux_s1_q    <= '0;
`endif
    end else begin
      qm_s1_q     <= qm_d;
      n1q_s1_q    <= n1q_d;
      de_s1_q     <= de;
      c_s1_q      <= c;
`ifdef SMOLDVI_TMDS_TERC4_EN
      island_s1_q <= island;
      aux_s1_q    <= aux;
`endif
    end
  end

  // Stage 2 next state: DC balancing for video, fixed symbols otherwise.
  // diff is n1q-n0q = 2*n1q-8, held in the counter's two's-complement width.
  always_comb begin
    diff    = (DISP_W'(n1q_s1_q) << 1) - DISP_W'(8);
    two     = DISP_W'(2);
    cntZero = (cnt_q == '0);
    cntNeg  = cnt_q[DISP_W-1];
    cntPos  = !cntNeg && !cntZero;
    encCase = ENC_PASS;
    sym_d   = CTRL_SYM[c_s1_q];
    cnt_d   = '0;

    if (cntZero || (n1q_s1_q == 4'd4)) begin
      encCase = ENC_BALANCED;
    end else if ((cntPos && (n1q_s1_q > 4'd4)) || (cntNeg && (n1q_s1_q < 4'd4))) begin
      encCase = ENC_INVERT;
    end

`ifdef SMOLDVI_TMDS_TERC4_EN
    if (island_s1_q) begin
      sym_d = TERC4_SYM[aux_s1_q];
      cnt_d = '0;
    end else
`endif
    if (de_s1_q) begin
      case (encCase)
        ENC_BALANCED: begin
          sym_d = {~qm_s1_q[8], qm_s1_q[8],
                   qm_s1_q[8] ? qm_s1_q[7:0] : ~qm_s1_q[7:0]};
          cnt_d = cnt_q + (qm_s1_q[8] ? diff : -diff);
        end
        ENC_INVERT: begin
          sym_d = {1'b1, qm_s1_q[8], ~qm_s1_q[7:0]};
          cnt_d = cnt_q + (qm_s1_q[8] ? two : '0) - diff;
        end
        default: begin
          sym_d = {1'b0, qm_s1_q[8], qm_s1_q[7:0]};
          cnt_d = cnt_q - (qm_s1_q[8] ? '0 : two) + diff;
        end
      endcase
    end else begin
      sym_d = CTRL_SYM[c_s1_q];
      cnt_d = '0;
    end
  end

  // Stage 2 registers: output symbol and running disparity.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sym_q <= CTRL_SYM[0];
      cnt_q <= '0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  // Board-level P/N swap compensation, applied to every symbol including reset.
  assign q_out = sym_q ^ {TMDS_W{INVERT_OUT}};

endmodule

// File: tb/tb_smoldvi_tmds_encode.sv
// tb_smoldvi_tmds_encode: directed bench for the smoldvi TMDS lane encoder.
// Honours SMOLDVI_TMDS_TERC4_EN to exercise the data-island path when built.
module tb_smoldvi_tmds_encode;

  logic       clk_pix = 1'b0;
  logic       rst_pix;
  logic       de;
  logic [7:0] d;
  logic [1:0] c;
`ifdef SMOLDVI_TMDS_TERC4_EN
  logic       island;
  logic [3:0] aux;
`endif
  logic [9:0] q_out;

  int compareCount = 0;
  int failCount    = 0;

  always #5 clk_pix = ~clk_pix;

  smoldvi_tmds_encode dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .de      (de),
    .d       (d),
    .c       (c),
`ifdef SMOLDVI_TMDS_TERC4_EN
    .island  (island),
    .aux     (aux),
`endif
    .q_out   (q_out)
  );

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic deIn, input logic [7:0] dIn, input logic [1:0] cIn);
    de = deIn;
    d  = dIn;
    c  = cIn;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] expected);
    checkValue(tag, {22'b0, q_out}, {22'b0, expected});
  endtask

  function automatic int cntNow();
    return int'($signed(dut.cnt_q));
  endfunction

  // Reference DVI encoder for one video byte, with integer disparity.
  task automatic modelEncode(input logic [7:0] din, input int cntIn,
                             output logic [9:0] sym, output int cntOut);
    int   ones, n1, n0;
    logic useXnor;
    logic [8:0] qm;
    ones    = $countones(din);
    useXnor = (ones > 4) || (ones == 4 && din[0] == 1'b0);
    qm[0]   = din[0];
    for (int i = 1; i < 8; i++) qm[i] = useXnor ? ~(qm[i-1] ^ din[i]) : (qm[i-1] ^ din[i]);
    qm[8]   = !useXnor;
    n1      = $countones(qm[7:0]);
    n0      = 8 - n1;
    if (cntIn == 0 || n1 == n0) begin
      sym    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cntOut = cntIn + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cntIn > 0 && n1 > n0) || (cntIn < 0 && n0 > n1)) begin
      sym    = {1'b1, qm[8], ~qm[7:0]};
      cntOut = cntIn + 2 * int'(qm[8]) + n0 - n1;
    end else begin
      sym    = {1'b0, qm[8], qm[7:0]};
      cntOut = cntIn - 2 * int'(!qm[8]) + n1 - n0;
    end
  endtask

  // Receiver-side TMDS video decode.
  task automatic decodeSym(input logic [9:0] q, output logic [7:0] dd);
    logic [7:0] low;
    low   = q[9] ? ~q[7:0] : q[7:0];
    dd[0] = low[0];
    for (int i = 1; i < 8; i++) dd[i] = q[8] ? (low[i] ^ low[i-1]) : ~(low[i] ^ low[i-1]);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] expPrev;
    logic [7:0] dPrev;
    logic [7:0] dRand;
    logic [7:0] dDec;
    int         modelCnt;
    int         cnt;

    rst_pix = 1'b1;
    de      = 1'b1;
    d       = 8'hFF;
    c       = 2'b00;
`ifdef SMOLDVI_TMDS_TERC4_EN
    island  = 1'b0;
    aux     = 4'h0;
`endif

    // Reset held three cycles with live video on the inputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hFF, 2'b00);
      checkOutput("resetHold", 10'h354);
    end
    rst_pix = 1'b0;
    #1;
    checkOutput("releaseOut0", 10'h354);
    applyStimulus(1'b1, 8'hFF, 2'b00);
    checkOutput("releaseOut1", 10'h354);
    applyStimulus(1'b1, 8'hFF, 2'b00);
    checkOutput("ffFirst", 10'h200);
    checkValue("cntAfterFf1", cntNow(), -8);
    applyStimulus(1'b0, 8'h00, 2'b00);
    checkOutput("ffSecond", 10'h0FF);
    checkValue("cntAfterFf2", cntNow(), -2);
    applyStimulus(1'b0, 8'h00, 2'b00);
    checkOutput("ctrlAfterFf", 10'h354);
    checkValue("cntCtrlClear", cntNow(), 0);

    // Two zero bytes from cnt=0.
    applyStimulus(1'b1, 8'h00, 2'b00);
    checkOutput("zeroPipeCtrl", 10'h354);
    applyStimulus(1'b1, 8'h00, 2'b00);
    checkOutput("zeroFirst", 10'h100);
    checkValue("cntZero1", cntNow(), -8);
    applyStimulus(1'b0, 8'h00, 2'b00);
    checkOutput("zeroSecond", 10'h3FF);
    checkValue("cntZero2", cntNow(), 2);

    // Control sweep.
    applyStimulus(1'b0, 8'h00, 2'b01);
    checkOutput("ctrl00", 10'h354);
    checkValue("cntAfterCtrl", cntNow(), 0);
    applyStimulus(1'b0, 8'h00, 2'b10);
    checkOutput("ctrl01", 10'h0AB);
    applyStimulus(1'b0, 8'h00, 2'b11);
    checkOutput("ctrl10", 10'h154);
    applyStimulus(1'b0, 8'h00, 2'b00);
    checkOutput("ctrl11", 10'h2AB);
    checkValue("cntCtrlSweep", cntNow(), 0);

    // Random video against the reference model.
    expPrev  = 10'h354;
    dPrev    = 8'h00;
    modelCnt = 0;
    for (int i = 0; i < 400; i++) begin
      dRand = 8'($urandom);
      applyStimulus(1'b1, dRand, 2'b00);
      checkOutput("randSym", expPrev);
      if (i > 0) begin
        decodeSym(q_out, dDec);
        checkValue("randDecode", {24'b0, dDec}, {24'b0, dPrev});
        cnt = cntNow();
        checkValue("randCnt", cnt, modelCnt);
        checkValue("randCntBound", {31'b0, (cnt >= -8) && (cnt <= 8) && (cnt % 2 == 0)}, 32'd1);
      end
      modelEncode(dRand, modelCnt, expPrev, modelCnt);
      dPrev = dRand;
    end
    applyStimulus(1'b0, 8'h00, 2'b00);
    checkOutput("randLast", expPrev);
    checkValue("randLastCnt", cntNow(), modelCnt);

    // Mid-stream reset with nonzero disparity.
    applyStimulus(1'b1, 8'h00, 2'b00);
    checkOutput("midPipeCtrl", 10'h354);
    applyStimulus(1'b1, 8'h00, 2'b00);
    checkOutput("midZero", 10'h100);
    checkValue("midCntBefore", cntNow(), -8);
    rst_pix = 1'b1;
    applyStimulus(1'b1, 8'h00, 2'b00);
    checkOutput("midResetOut", 10'h354);
    checkValue("midResetCnt", cntNow(), 0);
    rst_pix = 1'b0;
    applyStimulus(1'b1, 8'h00, 2'b00);
    checkOutput("midRelease", 10'h354);
    applyStimulus(1'b1, 8'h00, 2'b00);
    checkOutput("midRerun1", 10'h100);
    applyStimulus(1'b0, 8'h00, 2'b00);
    checkOutput("midRerun2", 10'h3FF);
    applyStimulus(1'b0, 8'h00, 2'b00);
    checkOutput("midCtrl", 10'h354);

`ifdef SMOLDVI_TMDS_TERC4_EN
    // Data island overriding de=1.
    island = 1'b1;
    aux    = 4'h0;
    applyStimulus(1'b1, 8'h00, 2'b00);
    checkOutput("islandPipe", 10'h354);
    island = 1'b0;
    applyStimulus(1'b0, 8'h00, 2'b00);
    checkOutput("islandTerc4", 10'h29C);
    checkValue("islandCnt", cntNow(), 0);
    applyStimulus(1'b0, 8'h00, 2'b00);
    checkOutput("islandExit", 10'h354);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
